// File: rtl/mbus_pkg.sv
// Shared definitions for the memory-bus fabric: FSM state encoding and the
// 4-bit region field that selects a slave from addr[15:12].
package mbus_pkg;

  localparam int REGION_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Identity map: slave k answers region k (up to 16 slaves).
  localparam logic [63:0] DEFAULT_REGIONS = 64'hFEDC_BA98_7654_3210;

endpackage

// File: rtl/mbus_fabric_if.sv
// Memory-bus bundle between one master, the fabric and NSLV slaves.
interface mbus_fabric_if #(
  parameter int WIDTH = 32,
  parameter int NSLV  = 8
);
  logic                  m_req;
  logic [WIDTH-1:0]      m_addr;
  logic [WIDTH-1:0]      m_wdata;
  logic                  m_wen;
  logic [WIDTH-1:0]      m_rdata;
  logic                  m_ready;
  logic                  m_err;

  logic [NSLV-1:0]       s_cs;
  logic [WIDTH-1:0]      s_addr;
  logic [WIDTH-1:0]      s_wdata;
  logic                  s_wen;
  logic [NSLV*WIDTH-1:0] s_rdata;
  logic [NSLV-1:0]       s_ready;

  modport master (output m_req, m_addr, m_wdata, m_wen,
                  input  m_rdata, m_ready, m_err);

  modport slave  (input  s_cs, s_addr, s_wdata, s_wen,
                  output s_rdata, s_ready);

  modport fabric (input  m_req, m_addr, m_wdata, m_wen,
                  output m_rdata, m_ready, m_err,
                  output s_cs, s_addr, s_wdata, s_wen,
                  input  s_rdata, s_ready);
endinterface

// File: rtl/mbus_addr_dec.sv
// Combinational address decoder: upper address bits -> one-hot slave select.
// Overlapping regions resolve to the lowest-numbered slave.
module mbus_addr_dec import mbus_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int NSLV  = 8,
  parameter logic [NSLV*REGION_W-1:0] SLV_REGION = DEFAULT_REGIONS[NSLV*REGION_W-1:0]
) (
  input  logic [WIDTH-13:0] addr_hi,
  output logic [NSLV-1:0]   sel,
  output logic              hit
);

  // Walk from the top so the lowest matching index is written last.
  always_comb begin
    sel = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (addr_hi[WIDTH-13:REGION_W] == '0 &&
          addr_hi[REGION_W-1:0] == SLV_REGION[k*REGION_W +: REGION_W]) begin
        sel    = '0;
        sel[k] = 1'b1;
      end
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/mbus_fabric.sv
// Single-master memory-bus fabric: decodes the request, holds the selected
// slave until it is ready or the wait budget runs out, then returns one strobe.
module mbus_fabric import mbus_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int NSLV  = 8,
  parameter logic [NSLV*REGION_W-1:0] SLV_REGION = DEFAULT_REGIONS[NSLV*REGION_W-1:0],
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  mbus_fabric_if.fabric     bus,
  output logic [15:0]       err_cnt,
  output logic [WIDTH-1:0]  err_addr
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]       state;
  logic [NSLV-1:0]  sel_q;
  logic [NSLV-1:0]  dec_sel;
  logic             dec_hit;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             wen_q;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;
  logic [7:0]       wait_cnt;
  logic [WIDTH-1:0] sel_rdata;
  logic             sel_ready;

  mbus_addr_dec #(
    .WIDTH      (WIDTH),
    .NSLV       (NSLV),
    .SLV_REGION (SLV_REGION)
  ) u_dec (
    .addr_hi (bus.m_addr[WIDTH-1:12]),
    .sel     (dec_sel),
    .hit     (dec_hit)
  );

  // Read mux and ready qualifier only look at the latched selection.
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q[k]) sel_rdata = sel_rdata | bus.s_rdata[k*WIDTH +: WIDTH];
    end
  end

  assign sel_ready = |(bus.s_ready & sel_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.m_req) begin
            addr_q   <= bus.m_addr;
            wdata_q  <= bus.m_wdata;
            wen_q    <= bus.m_wen;
            sel_q    <= dec_sel;
            wait_cnt <= '0;
            if (dec_hit) begin
              state <= ST_ACCESS;
            end else begin
              state    <= ST_RESP;
              err_q    <= 1'b1;
              rdata_q  <= '0;
              err_cnt  <= sat_inc(err_cnt);
              err_addr <= bus.m_addr;
            end
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            state   <= ST_RESP;
            rdata_q <= wen_q ? '0 : sel_rdata;
          end else if (wait_cnt == TIMEOUT_C) begin
            state    <= ST_RESP;
            err_q    <= 1'b1;
            rdata_q  <= '0;
            err_cnt  <= sat_inc(err_cnt);
            err_addr <= addr_q;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Selects decode straight from state so an async reset drops them at once.
  assign bus.s_cs    = (state == ST_ACCESS) ? sel_q : '0;
  assign bus.s_wen   = (state == ST_ACCESS) && wen_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
  assign bus.m_ready = (state == ST_RESP);
  assign bus.m_rdata = rdata_q;
  assign bus.m_err   = err_q;

endmodule
